dap_swd_transfer_ctrl: RTL
==========================

// Module: dap_swd_transfer_ctrl
// PURPOSE
//  Upstream feeder of the serial sequencer, in the controller clock domain.
//  - Takes single SWD transfer requests (DP/AP, read/write) from the DAP command decoder.
//  - Issues each request to the sequencer as one SEQ_CMD_SWD_TRANSFER command.
//  - Collects the ACK and read data, retries WAIT responses up to a programmed limit,
//    and returns one response per request to the response packer.
// PARAMETERS
//  TIMEOUT_CYCLES  65535  clk cycles allowed from command issue to sequencer result; 0 = no watchdog
//  RETRY_W         16     width of the WAIT retry limit/counter
// PORTS
//  clk             in   1        controller clock
//  resetn          in   1        synchronous active-low reset
//  cfg_wait_retry  in   RETRY_W  max WAIT retries per request; sampled on request accept
//  abort           in   1        pulse; stops further WAIT retries of the current request
//  req_valid       in   1        request handshake valid
//  req_ready       out  1        request handshake ready
//  req_ctrl        in   4        {A3,A2,RnW,APnDP}
//  req_wdata       in   32       write data; ignored for reads
//  rsp_valid       out  1        response handshake valid
//  rsp_ready       in   1        response handshake ready
//  rsp_ack         out  3        001 OK, 010 WAIT, 100 FAULT, 111 parity/protocol error, 000 timeout
//  rsp_rdata       out  32       read data; 0 for writes and for non-OK responses
//  rsp_retries     out  RETRY_W  number of WAIT retries performed
//  seq_tx_valid    out  1        level; sequencer detects its rising edge
//  seq_tx_cmd      out  16       [15:12]=`SEQ_CMD_SWD_TRANSFER, [11:4]=0, [3:0]=req_ctrl
//  seq_tx_data     out  64       {32'd0, wdata}
//  seq_tx_full     in   1        unused by the current sequencer; ignored
//  seq_rx_valid    in   1        level; rising edge = result present
//  seq_rx_flag     in   16       [2:0] = ACK code
//  seq_rx_data     in   64       [31:0] = read data
// BEHAVIOUR
//  Reset (resetn low at posedge clk):
//  - state IDLE; all outputs 0 (req_ready included); counters 0; rx edge register 0.
//  Handshakes:
//  - Transfer occurs on valid&&ready at posedge clk.
//  - req_ready = (state==IDLE) && !seq_rx_valid && resetn.
//  - rsp_* are held stable while rsp_valid && !rsp_ready.
//  - rx_rise = seq_rx_valid && !rx_prev; rx_prev is registered every cycle.
//  FSM:
//  - IDLE: on request accept, latch ctrl, wdata and cfg_wait_retry; retry_cnt=0; clear abort_seen.
//    Next cycle seq_tx_valid=1 with cmd/data stable. -> ISSUE.
//  - ISSUE: hold seq_tx_valid=1; wdog counts up.
//    - On rx_rise: capture ack=seq_rx_flag[2:0], rdata=seq_rx_data[31:0]; seq_tx_valid=0. -> RELEASE.
//    - If wdog reaches TIMEOUT_CYCLES: ack=000, rdata=0, seq_tx_valid=0. -> RELEASE.
//  - RELEASE: wait for seq_rx_valid==0; also for seq_tx_valid low >=4 clk so the sequencer's
//    2-flop sync sees the fall. -> EVAL.
//  - EVAL (1 cycle):
//    - If ack==010 && !abort_seen && retry_cnt<limit: retry_cnt+1, seq_tx_valid=1. -> ISSUE.
//    - Otherwise load rsp_* (rdata forced 0 unless ack==001 && RnW); rsp_valid=1. -> RESP.
//  - RESP: on rsp_ready, rsp_valid=0. -> IDLE.
//  Latencies:
//  - Request accept to seq_tx_valid rising: 1 cycle.
//  - seq_rx_valid falling (seen in RELEASE) to rsp_valid: <=2 cycles.
//  Boundary conditions:
//  - abort sets abort_seen in any state except IDLE; it never cuts an in-flight sequencer command.
//    The current command completes and its ACK is reported as-is.
//  - abort in IDLE is ignored.
//  - limit=0: WAIT is reported immediately with rsp_retries=0.
//  - retry_cnt saturates at its maximum and never wraps.
//  - rx_rise while in IDLE/RESP (stale result) is ignored; no request is accepted until it drops.
//  - Watchdog restarts on each (re)issue. A late result after a timeout arrives while IDLE and is
//    discarded per the stale rule above.
//  - Reset mid-operation drops seq_tx_valid the next cycle; the in-flight result is discarded as stale.
// STRUCTURE
//  - Shared include DAP_Cmd.v: `SEQ_CMD_SWD_TRANSFER; add DAP_ACK_OK/WAIT/FAULT/PERR/NONE codes there.
//  - Single module; no sub-module needed (edge detect and watchdog are inline).
// TESTING
//  - Read DP 0x0 (ctrl=4'b0010), sequencer model returns ack=001, data=0x2BA01477
//    -> seq_tx_cmd[3:0]=0010; rsp ack=001, rdata=0x2BA01477, retries=0.
//  - Write AP 0x4 (ctrl=4'b0101), wdata=0xA5A5_0F0F -> seq_tx_data=64'h0000_0000_A5A5_0F0F;
//    rsp ack=001, rdata=0.
//  - limit=3, model returns WAIT x2 then OK -> exactly 3 seq_tx_valid rising edges;
//    rsp ack=001, retries=2.
//  - limit=2, model always WAIT -> 3 issues; rsp ack=010, retries=2.
//  - limit=10, WAIT forever, abort pulse during 2nd issue -> 2 issues total; rsp ack=010, retries=1.
//  - TIMEOUT_CYCLES=100, model never answers -> seq_tx_valid falls at issue+100; rsp ack=000.
//    A late rx pulse afterwards is ignored; rsp_valid held 5 cycles with rsp_ready low stays stable.

Source files
------------

// File: rtl/dap_swd_transfer_ctrl_pkg.sv
// Shared constants for the SWD transfer controller: sequencer command code,
// ACK codes and the controller state encoding.
package dap_swd_transfer_ctrl_pkg;

   localparam logic [3:0] SEQ_CMD_SWD_TRANSFER = 4'h3;

   localparam logic [2:0] DAP_ACK_OK    = 3'b001;
   localparam logic [2:0] DAP_ACK_WAIT  = 3'b010;
   localparam logic [2:0] DAP_ACK_FAULT = 3'b100;
   localparam logic [2:0] DAP_ACK_PERR  = 3'b111;
   localparam logic [2:0] DAP_ACK_NONE  = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_RELEASE = 3'd2,
      ST_EVAL    = 3'd3,
      ST_RESP    = 3'd4
   } xfer_state_t;

   function automatic logic [15:0] mk_swd_cmd(input logic [3:0] ctrl);
      return {SEQ_CMD_SWD_TRANSFER, 8'h00, ctrl};
   endfunction

endpackage

// File: rtl/dap_swd_transfer_ctrl.sv
// Issues single SWD transfers to the serial sequencer, retries WAIT ACKs up to
// a programmed limit and returns one response per request.
module dap_swd_transfer_ctrl
   import dap_swd_transfer_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int RETRY_W        = 16
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [RETRY_W-1:0] cfg_wait_retry,
   input  logic               abort,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [3:0]         req_ctrl,
   input  logic [31:0]        req_wdata,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [2:0]         rsp_ack,
   output logic [31:0]        rsp_rdata,
   output logic [RETRY_W-1:0] rsp_retries,
   output logic               seq_tx_valid,
   output logic [15:0]        seq_tx_cmd,
   output logic [63:0]        seq_tx_data,
   input  logic               seq_tx_full,
   input  logic               seq_rx_valid,
   input  logic [15:0]        seq_rx_flag,
   input  logic [63:0]        seq_rx_data
);

   localparam logic [31:0] WDOG_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
   localparam bit          WDOG_EN   = (TIMEOUT_CYCLES > 0);

   xfer_state_t        state;
   logic               rx_prev;
   logic               rx_rise;
   logic [3:0]         ctrl_q;
   logic [RETRY_W-1:0] limit_q;
   logic [RETRY_W-1:0] retry_cnt;
   logic               abort_seen;
   logic [2:0]         ack_q;
   logic [31:0]        rdata_q;
   logic [31:0]        wdog;
   logic [2:0]         low_cnt;

   logic unused_ok;
   assign unused_ok = ^{seq_tx_full, seq_rx_flag[15:3], seq_rx_data[63:32]};

   assign rx_rise   = seq_rx_valid && !rx_prev;
   assign req_ready = (state == ST_IDLE) && !seq_rx_valid && resetn;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= ST_IDLE;
         rx_prev      <= 1'b0;
         ctrl_q       <= '0;
         limit_q      <= '0;
         retry_cnt    <= '0;
         abort_seen   <= 1'b0;
         ack_q        <= DAP_ACK_NONE;
         rdata_q      <= '0;
         wdog         <= '0;
         low_cnt      <= '0;
         rsp_valid    <= 1'b0;
         rsp_ack      <= '0;
         rsp_rdata    <= '0;
         rsp_retries  <= '0;
         seq_tx_valid <= 1'b0;
         seq_tx_cmd   <= '0;
         seq_tx_data  <= '0;
      end else begin
         rx_prev <= seq_rx_valid;
         if (abort && state != ST_IDLE)
            abort_seen <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  ctrl_q       <= req_ctrl;
                  limit_q      <= cfg_wait_retry;
                  retry_cnt    <= '0;
                  abort_seen   <= 1'b0;
                  wdog         <= '0;
                  seq_tx_valid <= 1'b1;
                  seq_tx_cmd   <= mk_swd_cmd(req_ctrl);
                  seq_tx_data  <= {32'd0, req_wdata};
                  state        <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               wdog <= wdog + 32'd1;
               // A real result wins over a watchdog expiry landing on the same cycle
               if (rx_rise) begin
                  ack_q        <= seq_rx_flag[2:0];
                  rdata_q      <= seq_rx_data[31:0];
                  seq_tx_valid <= 1'b0;
                  low_cnt      <= '0;
                  state        <= ST_RELEASE;
               end else if (WDOG_EN && wdog == WDOG_LAST) begin
                  ack_q        <= DAP_ACK_NONE;
                  rdata_q      <= '0;
                  seq_tx_valid <= 1'b0;
                  low_cnt      <= '0;
                  state        <= ST_RELEASE;
               end
            end

            ST_RELEASE: begin
               // Keep tx low long enough for the sequencer's synchroniser to see the fall
               if (low_cnt != 3'd7)
                  low_cnt <= low_cnt + 3'd1;
               if (!seq_rx_valid && low_cnt >= 3'd3)
                  state <= ST_EVAL;
            end

            ST_EVAL: begin
               if (ack_q == DAP_ACK_WAIT && !abort_seen && retry_cnt < limit_q) begin
                  if (retry_cnt != '1)
                     retry_cnt <= retry_cnt + 1'b1;
                  wdog         <= '0;
                  seq_tx_valid <= 1'b1;
                  state        <= ST_ISSUE;
               end else begin
                  rsp_valid   <= 1'b1;
                  rsp_ack     <= ack_q;
                  rsp_rdata   <= (ack_q == DAP_ACK_OK && ctrl_q[1]) ? rdata_q : 32'd0;
                  rsp_retries <= retry_cnt;
                  state       <= ST_RESP;
               end
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
